reg_pipe_rst_y_hs: RTL and testbench
====================================

Name: reg_pipe_rst_y_hs

Overview:
- Parametrised elastic register pipeline of DEPTH stages with a valid/ready handshake on both sides.
- Generalises the single enable-gated data register with:
  - synchronous active-high reset;
  - per-stage valid tracking;
  - bubble collapsing;
  - back-pressure;
  - flush;
  - an occupancy count.
- Used as a retiming or decoupling stage between producer/consumer blocks in the datapath.

Parameters:
- DATA_WIDTH, 32, width of the payload in bits.
- DEPTH, 4, number of register stages (legal range 1..16).
- RST_VAL, 0, value loaded into every stage data register on reset (DATA_WIDTH bits).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_flush  input  1  synchronous flush of all stages, active-high.
- i_valid  input  1  producer presents i_data.
- o_ready  output  1  pipeline accepts i_data this cycle.
- i_data  input  DATA_WIDTH  input payload.
- o_valid  output  1  last stage holds valid payload.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_data  output  DATA_WIDTH  last-stage payload.
- o_count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset and interface decisions:
  - Single clock i_clk.
  - Reset i_rst is synchronous and active-high.
- State:
  - Stage k (0 = input side, DEPTH-1 = output side) holds v[k] and d[k].
  - o_valid = v[DEPTH-1]; o_data = d[DEPTH-1].
- Reset (i_rst=1 at a rising edge):
  - All v[k] <= 0 and all d[k] <= RST_VAL.
  - After the edge: o_valid=0, o_data=RST_VAL, o_count=0.
- Advance condition, evaluated combinationally from the output side:
  - adv[DEPTH-1] = ~v[DEPTH-1] | i_ready.
  - adv[k] = ~v[k] | adv[k+1].
- Acceptance:
  - o_ready = adv[0] & ~i_rst & ~i_flush.
  - An input transfer occurs when i_valid & o_ready.
- Stage update when adv[k]=1:
  - v[k] <= v[k-1], with i_valid & o_ready substituted for v[k-1] at k=0.
  - d[k] loads only when its source is valid; otherwise d[k] holds.
  - Data registers never load invalid data.
- Stage update when adv[k]=0: v[k] and d[k] hold.
- Bubble collapsing: an empty stage always accepts, so a stall at the output fills the pipeline completely before o_ready drops.
- Latency and throughput:
  - Latency is DEPTH cycles from an input transfer to o_valid with no stalls.
  - Throughput is 1 transfer per cycle.
  - Full capacity is DEPTH entries.
- Output stability: while o_valid=1 and i_ready=0, o_data and o_valid hold until the transfer.
- Flush (i_flush=1, i_rst=0):
  - All v[k] <= 0; d[k] hold.
  - The input is not accepted (o_ready=0).
  - An output transfer during the flush cycle is still counted as taken by the consumer if i_ready=1.
- Priority: i_rst over i_flush; i_flush over normal operation.
- Reset mid-stream: in-flight entries are discarded. There is no partial output after the reset edge.
- o_count:
  - Registered.
  - Equals popcount of v after each edge.
  - Updated as count + in_xfer − out_xfer.
  - Cleared by reset and by flush.
  - Must never exceed DEPTH.
- Full/empty boundaries:
  - Full: o_count=DEPTH, i_ready=0 → o_ready=0.
  - Full with i_ready=1: o_ready=1, and a simultaneous in and out transfer leaves the count at DEPTH.
  - Empty with i_valid=0: o_count stays 0 and o_valid stays 0.
- DEPTH=1 degenerates to a single handshake register with the same rules.

Test Plan (DATA_WIDTH=32, DEPTH=4, RST_VAL=0):
1. Reset: hold i_rst 2 cycles with i_valid=1, i_data=0xFFFF0000 → o_valid=0, o_data=0x00000000, o_count=0, o_ready=0 throughout reset.
2. Streaming: i_ready=1; send 0x1, 0x2, 0x3 on consecutive cycles → o_data 0x1, 0x2, 0x3 on consecutive cycles, each appearing exactly 4 cycles after its input; no gaps.
3. Back-pressure: i_ready=0; send 0xA0..0xA5 → 4 entries accepted, o_ready=0 after the 4th, o_count=4, o_data held at 0xA0. Then i_ready=1 → outputs 0xA0..0xA5 in order, with no loss or duplication.
4. Bubble collapse: send 0xB0, idle 2 cycles, send 0xB1, with i_ready=0 → o_count=2; the stages adjacent to the output hold 0xB0 and 0xB1, so after release 0xB1 follows 0xB0 on the next cycle.
5. Flush: pipeline holding 3 entries, i_flush=1 for one cycle with i_valid=1, i_data=0xC0 → next cycle o_valid=0, o_count=0, and 0xC0 never appears at the output.
6. Full simultaneous transfer: pipeline full, i_valid=1 and i_ready=1 for 5 cycles with data 0xD0..0xD4 → o_count stays 4, o_ready stays 1, and outputs appear in FIFO order.

Source files
------------

// File: rtl/reg_pipe_rst_y_hs.sv
// Elastic register pipeline: DEPTH stages with per-stage valid bits,
// valid/ready handshake on both sides, bubble collapsing, flush and an
// occupancy counter. Used to retime or decouple datapath blocks.
module reg_pipe_rst_y_hs #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter int unsigned               DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0]     RST_VAL    = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Stage state: index 0 is the input side, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]      r_valid;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [CW-1:0]         r_count;

  // Per-stage advance enables and the value each stage would load.
  logic [DEPTH-1:0]      w_adv;
  logic [DEPTH-1:0]      w_src_valid;
  logic [DATA_WIDTH-1:0] w_src_data [DEPTH];
  logic                  w_in_xfer;
  logic                  w_out_xfer;

  // Advance chain resolved from the output side: an empty stage always
  // moves, so bubbles collapse before back-pressure reaches the input.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_adv = '0;
    w_adv[DEPTH-1] = ~r_valid[DEPTH-1] | i_ready;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      w_adv[k] = ~r_valid[k] | w_adv[k+1];
    end
  end

  // Input acceptance is blocked during reset and flush.
  assign o_ready    = w_adv[0] & ~i_rst & ~i_flush;
  assign w_in_xfer  = i_valid & o_ready;
  assign w_out_xfer = r_valid[DEPTH-1] & i_ready;

  // Source selection for each stage: the producer feeds stage 0, every other
  // stage is fed by its upstream neighbour.
  always_comb begin
    w_src_valid    = '0;
    w_src_valid[0] = w_in_xfer;
    w_src_data[0]  = i_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
    end
  end

  // Stage registers: reset clears everything, flush drops the valid bits,
  // otherwise advancing stages take their source and data loads only when
  // the source is valid.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value, which is what makes this a shift.
    if (i_rst) begin
      r_valid <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        // NOTE: the data registers are reset too because RST_VAL is visible
        // on o_data right after reset; this is a small register file, not RAM.
        r_data[k] <= RST_VAL;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_data[k] <= w_src_data[k];
          end
        end
      end
    end
  end

  // Occupancy counter tracks accepted minus delivered entries.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_count <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_count <= r_count + CW'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];
  assign o_count = r_count;

endmodule

// File: tb/tb_reg_pipe_rst_y_hs.sv
// Self-checking bench for reg_pipe_rst_y_hs with a FIFO scoreboard.
module tb_reg_pipe_rst_y_hs;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          i_rst, i_flush, i_valid, i_ready;
  logic [DW-1:0] i_data;
  logic          o_ready, o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;

  reg_pipe_rst_y_hs #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RST_VAL('0)) dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_flush(i_flush),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } ent_t;

  ent_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  bit            mon_en   = 0;
  bit            lat_chk  = 0;
  bit            seen_c0  = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops expected entries on output transfers, pushes on input
  // transfers, and checks count/ready/stability against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      ent_t e;
      bit   exp_rdy;
      exp_rdy = !i_rst && !i_flush && ((sb.size() < DEPTH) || i_ready);
      check("count", o_count, sb.size());
      check("ready", o_ready, exp_rdy);
      if (sb.size() == 0) check("empty_valid", o_valid, 0);
      if (prev_stall) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, prev_data);
      end
      if (o_valid && i_ready && !i_rst) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("data", o_data, e.data);
          if (lat_chk) check("latency", cyc - e.cyc, DEPTH);
        end
      end
      if (i_valid && o_ready) sb.push_back('{data: i_data, cyc: cyc});
      if (i_rst || i_flush) sb.delete();
      if (o_valid && o_data == 32'hC0) seen_c0 = 1;
      prev_stall = o_valid && !i_ready && !i_rst && !i_flush;
      prev_data  = o_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) step();
  endtask

  // Presents one item and holds it until accepted (bounded wait).
  task automatic send(input logic [DW-1:0] d);
    bit done = 0;
    i_valid = 1'b1;
    i_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (o_ready) done = 1;
      step();
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
    i_data = 32'hFFFF0000;

    // 1. Reset held two cycles with a valid input present.
    for (int i = 0; i < 2; i++) begin
      step();
      mon_en = 1;
      check("rst_valid", o_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_count", o_count, 0);
      check("rst_ready", o_ready, 0);
    end
    i_rst = 1'b0;
    idle(2);

    // 2. Streaming with exact latency.
    i_ready = 1'b1;
    lat_chk = 1;
    send(32'h1); send(32'h2); send(32'h3);
    idle(DEPTH + 3);
    lat_chk = 0;
    check("stream_drained", sb.size(), 0);

    // 3. Back-pressure fills the pipe, then releases in order.
    i_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(32'hA0 + i);
    i_valid = 1'b1; i_data = 32'hA4;
    @(negedge clk);
    check("bp_ready", o_ready, 0);
    check("bp_count", o_count, DEPTH);
    check("bp_data", o_data, 32'hA0);
    step();
    i_ready = 1'b1;
    send(32'hA4); send(32'hA5);
    idle(DEPTH + 3);
    check("bp_drained", sb.size(), 0);

    // 4. Bubble collapse.
    i_ready = 1'b0;
    send(32'hB0);
    idle(2);
    send(32'hB1);
    idle(6);
    check("bub_count", o_count, 2);
    check("bub_data0", o_data, 32'hB0);
    i_ready = 1'b1;
    @(negedge clk);
    check("bub_first", o_data, 32'hB0);
    step();
    @(negedge clk);
    check("bub_next_valid", o_valid, 1);
    check("bub_next_data", o_data, 32'hB1);
    idle(4);

    // 5. Flush discards in-flight entries and the concurrent input.
    i_ready = 1'b0;
    send(32'hE0); send(32'hE1); send(32'hE2);
    idle(4);
    check("fl_count_pre", o_count, 3);
    i_flush = 1'b1; i_valid = 1'b1; i_data = 32'hC0;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    check("fl_valid", o_valid, 0);
    check("fl_count", o_count, 0);
    i_ready = 1'b1;
    idle(DEPTH + 4);
    check("fl_no_c0", seen_c0, 0);

    // 6. Full pipe with simultaneous in/out transfers.
    i_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(32'hF0 + i);
    idle(2);
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_data = 32'hD0 + i;
      @(negedge clk);
      check("full_ready", o_ready, 1);
      check("full_count", o_count, DEPTH);
      step();
    end
    idle(DEPTH + 4);
    check("full_drained", sb.size(), 0);

    // Random mixed traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      i_data  = $urandom;
      i_flush = ($urandom_range(0, 31) == 0);
      step();
    end
    i_flush = 1'b0; i_ready = 1'b1;
    idle(DEPTH + 4);
    check("rand_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
